// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: shares a single parallel-prefix adder among NREQ requesters
// with round-robin arbitration, one operand pair per cycle.
//
// Optional feature: define ADD_RR_ARBITER_STATS_EN to add the stall_cnt output
// (saturating count of cycles with res_valid=1 and res_ready=0).
//
// Ports (add_rr_arbiter):
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready per-requester handshake (req_ready is a one-hot grant)
//   req_in1/in2     packed operands, slice i = [i*width +: width]
//   res_valid/ready result handshake
//   res, carry      registered sum and carry out of bit width-1
//   res_id          index of the requester that produced res
//   stall_cnt       (ADD_RR_ARBITER_STATS_EN only) stall cycle counter
//
// Ports (add):
//   in1, in2 -> sum, carry   Ladner-Fischer (minimum-depth) prefix adder

module add #(
  parameter int width = 74
) (
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  output logic [width-1:0] sum,
  output logic             carry
);
  localparam int LVL = (width > 1) ? $clog2(width) : 1;

  logic [width-1:0] p0, g, p, gn, pn;
  logic [width:0]   c;

  assign p0 = in1 ^ in2;

  // Each level l merges every node whose bit l is set with the top node of
  // the preceding 2^l-aligned block, so after LVL levels g[i] spans [i:0].
  always_comb begin
    g  = in1 & in2;
    p  = p0;
    gn = '0;
    pn = '0;
    for (int l = 0; l < LVL; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < width; i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
          pn[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
      g = gn;
      p = pn;
    end
  end

  assign c     = {g, 1'b0};
  assign sum   = p0 ^ c[width-1:0];
  assign carry = c[width];
endmodule

module add_rr_arbiter #(
  parameter int width = 74,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*width-1:0] req_in1,
  input  logic [NREQ*width-1:0] req_in2,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [width-1:0]      res,
  output logic                  carry,
  output logic [IDW-1:0]        res_id
`ifdef ADD_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  logic [IDW-1:0]   rr_ptr, winner;
  logic [NREQ-1:0]  gnt;
  logic             any, accept_ok, accept;
  logic [width-1:0] op1, op2, sum;
  logic             cout;
  int               idx;

  // Rotating scan from rr_ptr; operands follow the same selection so the
  // adder sees the winner's pair in the grant cycle.
  always_comb begin
    winner = '0;
    gnt    = '0;
    any    = 1'b0;
    op1    = '0;
    op2    = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any      = 1'b1;
        winner   = IDW'(idx);
        gnt[idx] = 1'b1;
        op1      = req_in1[idx*width +: width];
        op2      = req_in2[idx*width +: width];
      end
    end
  end

  assign accept_ok = !res_valid || res_ready;
  assign req_ready = (!rst && accept_ok && any) ? gnt : '0;
  assign accept    = |(req_ready & req_valid);

  add #(.width(width)) u_add (
    .in1   (op1),
    .in2   (op2),
    .sum   (sum),
    .carry (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res       <= '0;
      carry     <= 1'b0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      res       <= sum;
      carry     <= cout;
      res_id    <= winner;
      res_valid <= 1'b1;
      rr_ptr    <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ADD_RR_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (res_valid && !res_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_add_rr_arbiter.sv
// Directed bench for add_rr_arbiter (width=8, NREQ=4). Inputs are driven 1ns
// after the rising edge; outputs are sampled in the same window.
module tb_add_rr_arbiter;
  localparam int W = 8, N = 4, IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*W-1:0]  req_in1, req_in2;
  logic            res_valid, res_ready, carry;
  logic [W-1:0]    res;
  logic [IW-1:0]   res_id;
`ifdef ADD_RR_ARBITER_STATS_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     sc0;
`endif

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  add_rr_arbiter #(.width(W), .NREQ(N), .IDW(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .carry(carry), .res_id(res_id)
`ifdef ADD_RR_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_sum [N];

  initial begin
    rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b0;
    req_in1 = '0; req_in2 = '0;
    tick(); tick();
    // reset state
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_carry", carry, 0);
    chk("rst_id", res_id, 0);

    // single requester 2
    rst = 1'b0; req_valid = 4'b0100; res_ready = 1'b1;
    req_in1[2*W +: W] = 8'h3C; req_in2[2*W +: W] = 8'h05;
    #1 chk("single_ready", req_ready, 4'b0100);
    tick();
    chk("single_res", res, 8'h41);
    chk("single_carry", carry, 0);
    chk("single_id", res_id, 2);
    chk("single_valid", res_valid, 1);

    // idle drain: valid drops, payload holds
    req_valid = 4'b0000;
    #1 chk("idle_ready", req_ready, 4'b0000);
    tick();
    chk("drain_valid", res_valid, 0);
    chk("drain_res_hold", res, 8'h41);
    chk("drain_id_hold", res_id, 2);

    // carry/wrap on requester 3 (pointer is at 3 after the grant to 2)
    req_valid = 4'b1000;
    req_in1[3*W +: W] = 8'hFF; req_in2[3*W +: W] = 8'h01;
    #1 chk("wrap_ready", req_ready, 4'b1000);
    tick();
    chk("wrap_res", res, 8'h00);
    chk("wrap_carry", carry, 1);
    chk("wrap_id", res_id, 3);

    // fairness: pointer wrapped to 0, all requesting, drain+accept each cycle
    for (int i = 0; i < N; i++) begin
      req_in1[i*W +: W] = 8'(8'h10 * i + 1);
      req_in2[i*W +: W] = 8'h02;
    end
    exp_sum[0] = 8'h03; exp_sum[1] = 8'h13; exp_sum[2] = 8'h23; exp_sum[3] = 8'h33;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("fair_ready%0d", k), req_ready, 32'(4'b0001 << (k % N)));
      tick();
      chk($sformatf("fair_id%0d", k), res_id, k % N);
      chk($sformatf("fair_valid%0d", k), res_valid, 1);
      chk($sformatf("fair_res%0d", k), res, exp_sum[k % N]);
      chk($sformatf("fair_carry%0d", k), carry, 0);
    end

    // backpressure for 3 cycles: holding res=03, id=0
    res_ready = 1'b0;
`ifdef ADD_RR_ARBITER_STATS_EN
    sc0 = stall_cnt;
`endif
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp_ready%0d", k), req_ready, 4'b0000);
      tick();
      chk($sformatf("bp_res%0d", k), res, 8'h03);
      chk($sformatf("bp_id%0d", k), res_id, 0);
      chk($sformatf("bp_valid%0d", k), res_valid, 1);
    end
`ifdef ADD_RR_ARBITER_STATS_EN
    chk("stall_cnt", stall_cnt, 32'(sc0 + 16'd3));
`endif

    // drain and accept same cycle (pointer at 1, only 0 requests)
    res_ready = 1'b1; req_valid = 4'b0001;
    req_in1[0 +: W] = 8'h20; req_in2[0 +: W] = 8'h22;
    #1 chk("da_ready", req_ready, 4'b0001);
    tick();
    chk("da_valid", res_valid, 1);
    chk("da_id", res_id, 0);
    chk("da_res", res, 8'h42);

    // reset during stall
    res_ready = 1'b0; req_valid = 4'b1111; rst = 1'b1;
    #1 chk("rs_ready_in_rst", req_ready, 4'b0000);
    tick();
    chk("rs_valid", res_valid, 0);
    chk("rs_id", res_id, 0);
    chk("rs_res", res, 0);
    chk("rs_ready", req_ready, 4'b0000);
`ifdef ADD_RR_ARBITER_STATS_EN
    chk("rs_stall_cnt", stall_cnt, 0);
`endif
    // pointer back at 0 after reset (it was 1 before)
    rst = 1'b0; res_ready = 1'b1;
    #1 chk("rs_ptr", req_ready, 4'b0001);
    tick();
    chk("rs_first_id", res_id, 0);
    chk("rs_first_res", res, 8'h42);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
